memory_data_buffer: RTL

//  Parametrised successor to the single-word memory data register (MDR).

---
 rtl/memory_data_buffer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/memory_data_buffer.sv
// -----------------------------------------------------------------------------
// memory_data_buffer
//
// Purpose:
//   Parametrised successor to the single-word memory data register (MDR).
//   Sits between the data memory read port and the CPU write-back mux.
//   Read data is captured with a valid/ready handshake into a DEPTH-entry
//   FIFO. This lets the control FSM issue back-to-back loads without losing
//   data. A word pushed at a clock edge is visible on data_out right after
//   that edge, which is the same one-cycle latency as the old MDR. There is
//   no combinational bypass from mem_data to data_out.
//
// Configuration macro:
//   MDB_LANE_EXTRACT_EN
//     Defined:   byte/halfword lanes are selected by ld_offset at capture
//                time and sign/zero extended. The FIFO holds the final value.
//     Undefined: every entry stores mem_data unchanged. ld_size, ld_signed
//                and ld_offset are ignored but remain ports. Handshake and
//                timing are identical in both builds.
//
// Parameters:
//   W      data width in bits (multiple of 16, >= 16)
//   DEPTH  FIFO entries (power of 2, >= 2)
//
// Ports:
//   clock      in   rising-edge clock
//   resetn     in   synchronous reset, active-low
//   flush      in   synchronous clear of all entries (below reset in priority)
//   mem_valid  in   mem_data is valid this cycle
//   mem_ready  out  buffer can accept (not full); forced 0 while in reset
//   mem_data   in   raw memory read word
//   ld_size    in   0=byte 1=half 2=word 3=word (reserved)
//   ld_signed  in   1=sign-extend, 0=zero-extend
//   ld_offset  in   byte address low bits of the load
//   out_valid  out  data_out holds the oldest entry
//   out_ready  in   consumer takes the oldest entry this cycle
//   data_out   out  oldest entry, 0 when out_valid=0
//   count      out  number of entries held
// -----------------------------------------------------------------------------
module memory_data_buffer #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int OFS_W = $clog2(W / 8),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             flush,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [W-1:0]     mem_data,
  input  logic [1:0]       ld_size,
  input  logic             ld_signed,
  input  logic [OFS_W-1:0] ld_offset,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     data_out,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [W-1:0]     storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [W-1:0]     push_value;
  logic             push;
  logic             pop;

  // Handshake status is derived from the registered count only, so there is
  // no combinational path from out_ready to mem_ready. When full, mem_ready
  // stays low even if the consumer pops in the same cycle. Both flags are
  // held low while reset is asserted.
  always_comb begin
    mem_ready = resetn && (count_q != FULL_COUNT);
    out_valid = resetn && (count_q != '0);
    push      = mem_valid && mem_ready;
    pop       = out_valid && out_ready;
    count     = count_q;
    data_out  = out_valid ? storage[rd_ptr] : '0;
  end

`ifdef MDB_LANE_EXTRACT_EN
  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;
  logic [OFS_W-1:0] half_idx;

  // Lane selection happens at capture, so the FIFO stores the value
  // already extended. For halfword loads the offset LSB is dropped. This
  // selects the aligned halfword that contains the addressed byte.
  always_comb begin
    half_idx   = ld_offset >> 1;
    byte_lane  = mem_data[8 * int'(ld_offset) +: 8];
    half_lane  = mem_data[16 * int'(half_idx) +: 16];
    push_value = mem_data;
    case (ld_size)
      2'd0:    push_value = {{(W - 8){ld_signed & byte_lane[7]}}, byte_lane};
      2'd1:    push_value = {{(W - 16){ld_signed & half_lane[15]}}, half_lane};
      default: push_value = mem_data;
    endcase
  end
`else
  logic unused_ld_fields;

  // Without lane extraction every entry stores the raw word. The load
  // qualifiers are kept as ports so the interface is identical.
  always_comb begin
    push_value       = mem_data;
    unused_ld_fields = ^{ld_size, ld_signed, ld_offset};
  end
`endif

  // The storage array is deliberately not reset. Entries only become
  // observable after the count says they were written. A push in a flush
  // cycle is discarded, so the array is left untouched in that case.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      storage[wr_ptr] <= push_value;
    end
  end

  // Pointer and count bookkeeping. Priority is reset, then flush, then
  // push/pop. Pointers wrap naturally because DEPTH is a power of two. The
  // count cannot exceed DEPTH because push is gated by mem_ready, and it
  // cannot underflow because pop is gated by out_valid.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule
